// File: rtl/spatz_vrf_wport_arbiter_pkg.sv
// Shared types for the VRF write-port arbiter: VRF word/payload types,
// the arbitration FSM encoding and the requester-index width helper.
package spatz_vrf_wport_arbiter_pkg;

  localparam int unsigned VRegAddrWidth = 10;
  localparam int unsigned VRegDataWidth = 64;
  localparam int unsigned VRegBeWidth   = VRegDataWidth / 8;

  typedef logic [VRegAddrWidth-1:0] vreg_addr_t;
  typedef logic [VRegDataWidth-1:0] vreg_data_t;
  typedef logic [VRegBeWidth-1:0]   vreg_be_t;

  typedef struct packed {
    vreg_addr_t addr;
    vreg_data_t data;
    vreg_be_t   be;
    logic       last;
  } vrf_wreq_t;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } wport_state_e;

  // Matches cf_math_pkg::idx_width: a single requester still needs one index bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spatz_rr_picker.sv
// Round-robin picker: first valid requester at or after ptr_i (mod NrReq),
// returned both as a onehot grant and as an index.
module spatz_rr_picker
  import spatz_vrf_wport_arbiter_pkg::*;
#(
  parameter int unsigned NrReq    = 2,
  parameter int unsigned IdxWidth = idx_width(NrReq)
) (
  input  logic [NrReq-1:0]    valid_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [NrReq-1:0]    grant_o,
  output logic [IdxWidth-1:0] idx_o
);

  logic w_found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NrReq; k++) begin
      if (!w_found && valid_i[(32'(ptr_i) + k) % NrReq]) begin
        grant_o[(32'(ptr_i) + k) % NrReq] = 1'b1;
        idx_o   = IdxWidth'((32'(ptr_i) + k) % NrReq);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spatz_vrf_wport_arbiter.sv
// Shares VRF write port 0 between NrReq requesters: round-robin grant,
// multi-beat group locking and a one-entry output register toward the VRF.
module spatz_vrf_wport_arbiter
  import spatz_vrf_wport_arbiter_pkg::*;
#(
  parameter int unsigned NrReq    = 2,
  parameter int unsigned IdxWidth = idx_width(NrReq)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic       [NrReq-1:0]       req_valid_i,
  output logic       [NrReq-1:0]       req_ready_o,
  input  vreg_addr_t [NrReq-1:0]       req_addr_i,
  input  vreg_data_t [NrReq-1:0]       req_data_i,
  input  vreg_be_t   [NrReq-1:0]       req_be_i,
  input  logic       [NrReq-1:0]       req_last_i,
  output logic                         vrf_we_o,
  output vreg_addr_t                   vrf_waddr_o,
  output vreg_data_t                   vrf_wdata_o,
  output vreg_be_t                     vrf_wbe_o,
  input  logic                         vrf_wvalid_i,
  output logic                         busy_o,
  output logic       [IdxWidth-1:0]    owner_o
);

  wport_state_e          r_state, w_state_nxt;
  logic [IdxWidth-1:0]   r_owner, r_rr_ptr;
  logic [IdxWidth-1:0]   w_pick_idx, w_sel_idx, w_ptr_nxt;
  logic [NrReq-1:0]      w_pick_grant, w_grant;
  logic                  r_out_valid, w_out_free, w_accept;
  vreg_addr_t            r_waddr;
  vreg_data_t            r_wdata;
  vreg_be_t              r_wbe;
  vrf_wreq_t             w_sel;

  spatz_rr_picker #(
    .NrReq   (NrReq),
    .IdxWidth(IdxWidth)
  ) i_picker (
    .valid_i(req_valid_i),
    .ptr_i  (r_rr_ptr),
    .grant_o(w_pick_grant),
    .idx_o  (w_pick_idx)
  );

  // A locked group grants its owner even while the owner idles, so no one else can slip in.
  always_comb begin
    w_grant   = w_pick_grant;
    w_sel_idx = w_pick_idx;
    if (r_state == ST_LOCKED) begin
      w_grant   = {{(NrReq-1){1'b0}}, 1'b1} << r_owner;
      w_sel_idx = r_owner;
    end
  end

  assign w_out_free  = !r_out_valid || vrf_wvalid_i;
  assign req_ready_o = w_grant & {NrReq{w_out_free && !rst_i}};
  assign w_accept    = |(req_valid_i & req_ready_o);

  always_comb begin
    w_sel.addr = req_addr_i[w_sel_idx];
    w_sel.data = req_data_i[w_sel_idx];
    w_sel.be   = req_be_i[w_sel_idx];
    w_sel.last = req_last_i[w_sel_idx];
  end

  assign w_ptr_nxt = (w_sel_idx == IdxWidth'(NrReq - 1)) ? '0 : w_sel_idx + IdxWidth'(1);

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      case (r_state)
        ST_IDLE:   if (!w_sel.last) w_state_nxt = ST_LOCKED;
        ST_LOCKED: if (w_sel.last)  w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_wbe       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_waddr     <= w_sel.addr;
        r_wdata     <= w_sel.data;
        r_wbe       <= w_sel.be;
        r_owner     <= w_sel_idx;
        if (w_sel.last) r_rr_ptr <= w_ptr_nxt;
      end else if (vrf_wvalid_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign vrf_we_o    = r_out_valid;
  assign vrf_waddr_o = r_waddr;
  assign vrf_wdata_o = r_wdata;
  assign vrf_wbe_o   = r_wbe;
  assign busy_o      = r_out_valid || (r_state == ST_LOCKED);
  assign owner_o     = r_owner;

  for (genvar g = 0; g < NrReq; g++) begin : g_req_rules
    a_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      (req_valid_i[g] && !req_ready_o[g]) |=>
        (req_valid_i[g] && $stable(req_addr_i[g]) && $stable(req_data_i[g]) &&
         $stable(req_be_i[g]) && $stable(req_last_i[g])));
  end

  a_ack_only_when_we: assert property (@(posedge clk_i) disable iff (rst_i)
    vrf_wvalid_i |-> vrf_we_o);

  a_ready_onehot0: assert property (@(posedge clk_i) $onehot0(req_ready_o));

endmodule

// File: tb/tb_spatz_vrf_wport_arbiter.sv
// Bench for the VRF write-port arbiter (3 requesters): directed scenarios
// followed by random traffic, all checked against a transaction-level model.
module tb_spatz_vrf_wport_arbiter;
  import spatz_vrf_wport_arbiter_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned IW = idx_width(N);

  logic                   clk = 1'b0;
  logic                   rst;
  logic       [N-1:0]     valid, ready, last;
  vreg_addr_t [N-1:0]     addr;
  vreg_data_t [N-1:0]     data;
  vreg_be_t   [N-1:0]     be;
  logic                   we, wvalid, busy;
  vreg_addr_t             waddr;
  vreg_data_t             wdata;
  vreg_be_t               wbe;
  logic       [IW-1:0]    owner;

  spatz_vrf_wport_arbiter #(
    .NrReq(N)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (valid),
    .req_ready_o (ready),
    .req_addr_i  (addr),
    .req_data_i  (data),
    .req_be_i    (be),
    .req_last_i  (last),
    .vrf_we_o    (we),
    .vrf_waddr_o (waddr),
    .vrf_wdata_o (wdata),
    .vrf_wbe_o   (wbe),
    .vrf_wvalid_i(wvalid),
    .busy_o      (busy),
    .owner_o     (owner)
  );

  always #5 clk = ~clk;

  // Transaction-level model: output slot contents, group lock and fairness pointer.
  bit          m_ov, m_locked;
  vreg_addr_t  m_addr;
  vreg_data_t  m_data;
  vreg_be_t    m_be;
  int unsigned m_owner, m_ptr;
  logic [N-1:0] m_acc;

  int          n_vec = 0, n_err = 0;
  int          ack_mode;
  int unsigned glog[$];
  int unsigned grp_left[N];
  logic [N-1:0] s_ready;
  logic         s_we, s_busy;
  vreg_addr_t   s_waddr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ov = 0; m_locked = 0; m_addr = '0; m_data = '0; m_be = '0;
    m_owner = 0; m_ptr = 0;
  endtask

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (rst || (m_ov && !wvalid)) return r;
    if (m_locked) begin
      r[m_owner] = 1'b1;
      return r;
    end
    for (int unsigned k = 0; k < N; k++) begin
      if (valid[(m_ptr + k) % N]) begin
        r[(m_ptr + k) % N] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic load(input int unsigned i, input logic l);
    addr[i]  = vreg_addr_t'($urandom);
    data[i]  = {$urandom, $urandom};
    be[i]    = vreg_be_t'($urandom);
    last[i]  = l;
    valid[i] = 1'b1;
  endtask

  // One clock: drive ack, check at posedge+2, advance model at the edge.
  task automatic tick();
    logic [N-1:0] er;
    int unsigned  ai;
    if (rst) wvalid = 1'b0;
    else case (ack_mode)
      0:       wvalid = 1'b0;
      1:       wvalid = m_ov;
      default: wvalid = m_ov && ($urandom_range(0, 2) != 0);
    endcase
    #1;
    if (rst) model_reset();
    er = exp_ready();
    s_ready = ready; s_we = we; s_busy = busy; s_waddr = waddr;
    chk("ready", 64'(ready), 64'(er));
    chk("we", 64'(we), 64'(m_ov));
    chk("busy", 64'(busy), 64'(m_ov || m_locked));
    chk("owner", 64'(owner), 64'(m_owner));
    chk("waddr", 64'(waddr), 64'(m_addr));
    chk("wdata", wdata, m_data);
    chk("wbe", 64'(wbe), 64'(m_be));
    m_acc = er & valid;
    ai = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (valid[i] && ready[i]) glog.push_back(i);
      if (m_acc[i]) ai = i;
    end
    @(posedge clk);
    if (!rst) begin
      if (m_acc != '0) begin
        m_ov = 1; m_addr = addr[ai]; m_data = data[ai]; m_be = be[ai]; m_owner = ai;
        if (last[ai]) begin
          m_locked = 0;
          m_ptr = (ai + 1) % N;
        end else begin
          m_locked = 1;
        end
      end else if (wvalid) begin
        m_ov = 0;
      end
    end
    #1;
  endtask

  task automatic wait_acc(input int unsigned i, input string tag);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m_acc[i]) return;
    end
    n_vec++;
    n_err++;
    $error("FAIL %s: requester %0d not accepted within 20 cycles", tag, i);
  endtask

  initial begin
    vreg_addr_t a0, a1;
    rst = 1'b1; valid = '0; last = '0; addr = '0; data = '0; be = '0; wvalid = 1'b0;
    ack_mode = 1;
    model_reset();
    tick(); tick();
    chk("rst_we", 64'(s_we), 64'(0));
    chk("rst_busy", 64'(s_busy), 64'(0));
    rst = 1'b0;

    // Single beat: accept, then visible on the VRF side one cycle later.
    load(0, 1'b1); addr[0] = 10'd5; data[0] = 64'hA5A5_A5A5_A5A5_A5A5; be[0] = '1;
    tick();
    chk("t1_ready", 64'(s_ready), 64'(3'b001));
    valid[0] = 1'b0;
    tick();
    chk("t1_we", 64'(s_we), 64'(1));
    chk("t1_addr", 64'(s_waddr), 64'(5));
    load(0, 1'b1); load(1, 1'b1);
    tick();
    chk("t1_ptr", 64'(s_ready), 64'(3'b010));
    valid[1] = 1'b0;

    // Fairness: req0 pending from above, rr_ptr=2 so the first pick wraps to 0.
    glog.delete();
    load(1, 1'b1);
    for (int c = 0; c < 20 && glog.size() < 6; c++) begin
      tick();
      for (int unsigned i = 0; i < 2; i++)
        if (m_acc[i]) begin
          if (glog.size() <= 4) load(i, 1'b1);
          else valid[i] = 1'b0;
        end
    end
    chk("t2_count", 64'(glog.size()), 64'(6));
    chk("t6_wrap", 64'(glog.size() > 0 ? glog[0] : 99), 64'(0));
    for (int unsigned k = 1; k < 6; k++)
      chk("t2_order", 64'(glog.size() > k ? glog[k] : 99), 64'(k % 2));

    // Lock: 4-beat group from req0 with a bubble, req1 waiting throughout.
    glog.delete();
    load(1, 1'b1);
    for (int unsigned b = 0; b < 4; b++) begin
      load(0, b == 3);
      wait_acc(0, "t3_beat");
      valid[0] = 1'b0;
      if (b == 1) begin
        tick();
        chk("t3_bubble", 64'(s_ready[1]), 64'(0));
      end
    end
    wait_acc(1, "t3_req1");
    valid[1] = 1'b0;
    chk("t3_count", 64'(glog.size()), 64'(5));
    for (int unsigned k = 0; k < 5; k++)
      chk("t3_order", 64'(glog.size() > k ? glog[k] : 99), 64'(k == 4 ? 1 : 0));

    // Back-pressure: full output slot, no ack for 3 cycles.
    tick();
    ack_mode = 0;
    load(0, 1'b1);
    a0 = addr[0];
    tick();
    valid[0] = 1'b0;
    load(1, 1'b1);
    a1 = addr[1];
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t4_ready", 64'(s_ready), 64'(0));
      chk("t4_hold", 64'(s_waddr), 64'(a0));
    end
    ack_mode = 1;
    tick();
    chk("t4_accept", 64'(s_ready), 64'(3'b010));
    chk("t4_we_held", 64'(s_we), 64'(1));
    valid[1] = 1'b0;
    tick();
    chk("t4_we", 64'(s_we), 64'(1));
    chk("t4_addr", 64'(s_waddr), 64'(a1));

    // Reset in the middle of a 4-beat group.
    load(0, 1'b0); wait_acc(0, "t5_b1");
    load(0, 1'b0); wait_acc(0, "t5_b2");
    valid[0] = 1'b0;
    load(1, 1'b1);
    rst = 1'b1;
    tick();
    chk("t5_we", 64'(s_we), 64'(0));
    chk("t5_ready", 64'(s_ready), 64'(0));
    chk("t5_busy", 64'(s_busy), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    chk("t5_first", 64'(s_ready), 64'(3'b010));
    valid[1] = 1'b0;

    // Random traffic: groups of 1-4 beats with bubbles and random VRF acks.
    ack_mode = 2;
    for (int unsigned i = 0; i < N; i++) grp_left[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int unsigned i = 0; i < N; i++)
        if (!valid[i] && $urandom_range(0, 3) == 0) begin
          if (grp_left[i] == 0) grp_left[i] = $urandom_range(1, 4);
          load(i, grp_left[i] == 1);
        end
      tick();
      for (int unsigned i = 0; i < N; i++)
        if (m_acc[i]) begin
          valid[i] = 1'b0;
          grp_left[i]--;
        end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
